ring_osc_freq_meter: RTL and testbench

// Measures the frequency of the divided ring-oscillator output (clk_out of the
// on-chip ring oscillator) in the system clock domain. Samples the asynchronous

---
 rtl/ring_osc_freq_meter.sv | 106 ++++++++++
 tb/tb_ring_osc_freq_meter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: synchronizes osc_in, counts its rising edges
// over a fixed gate window of system clocks, and returns the count on a valid/ready port.
module ring_osc_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int GATE_WIDTH  = 24,
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   osc_in_i,
  input  logic                   start_i,
  input  logic                   continuous_i,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] result_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic                   overflow_o
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, HOLD} state_e;

  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic [GATE_WIDTH-1:0]  timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_pulse;

  // Synchronizer and edge history run in every state so the first GATE cycle
  // already sees a settled edge detector.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], osc_in_i};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = ARM;
      end
      ARM: begin
        timer_d = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = GATE;
      end
      GATE: begin
        timer_d = timer_q + GATE_WIDTH'(1);
        // Saturate instead of wrapping; an edge at full scale flags overflow.
        if (edge_pulse) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
        // cnt_d already includes an edge landing in the last gate cycle.
        if (timer_q == GATE_LAST) begin
          result_d = cnt_d;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (result_ready_i) state_d = continuous_i ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == HOLD);
  assign result_o       = result_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Scoreboard bench for ring_osc_freq_meter: stimulus pushes expected results,
// a negedge monitor pops and compares them on each result handshake.
module tb_ring_osc_freq_meter;
  localparam int G  = 100;
  localparam int CW = 4;

  logic          clk = 1'b0, reset = 1'b1, osc = 1'b0, start = 1'b0;
  logic          cont = 1'b0, ready = 1'b1;
  logic          busy, valid, overflow;
  logic [CW-1:0] result;

  ring_osc_freq_meter #(
    .GATE_CYCLES(G), .GATE_WIDTH(8), .COUNT_WIDTH(CW), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .osc_in_i(osc), .start_i(start),
    .continuous_i(cont), .busy_o(busy), .result_o(result),
    .result_valid_o(valid), .result_ready_i(ready), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator synchronous to clk so each window holds an exact edge count;
  // period is 2*osc_half cycles, osc_half==0 holds it low.
  int osc_half = 0;
  int ph = 0;
  initial forever begin
    @(negedge clk);
    if (osc_half == 0) begin
      osc = 1'b0;
      ph  = 0;
    end else begin
      ph++;
      if (ph >= osc_half) begin
        ph  = 0;
        osc = ~osc;
      end
    end
  end

  typedef struct {
    logic [CW-1:0] res;
    logic          ovf;
    int            vcyc;
  } exp_t;
  exp_t sbq[$];

  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  int            rise_cyc = -1;
  logic [CW-1:0] rise_res;
  exp_t          e;

  always @(negedge clk) begin
    if (reset) rise_cyc = -1;
    else if (valid) begin
      if (rise_cyc < 0) begin
        rise_cyc = cyc;
        rise_res = result;
      end
      if (ready) begin
        if (sbq.size() == 0) chk("unexpected_valid", int'(valid), 0);
        else begin
          e = sbq.pop_front();
          chk("result", int'(result), int'(e.res));
          chk("overflow", int'(overflow), int'(e.ovf));
          chk("valid_cycle", rise_cyc, e.vcyc);
          chk("result_stable", int'(result), int'(rise_res));
        end
        rise_cyc = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] r, input logic o, input int vc);
    exp_t x;
    x.res = r; x.ovf = o; x.vcyc = vc;
    sbq.push_back(x);
  endtask

  task automatic start_meas(input logic [CW-1:0] r, input logic o);
    push(r, o, cyc + 2 + G);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int c, n, bad;
    // reset with oscillator toggling
    osc_half = 3;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    tick();

    // basic: period 10, 100-cycle window -> 10 edges
    osc_half = 5;
    repeat (20) tick();
    start_meas(4'd10, 1'b0);
    wait_idle(300);

    // saturation: period 4 -> 25 edges, clamps at 15
    osc_half = 2;
    repeat (20) tick();
    start_meas(4'd15, 1'b1);
    wait_idle(300);

    // backpressure: hold result 50 cycles, start ignored in HOLD
    osc_half = 5;
    ready = 1'b0;
    repeat (20) tick();
    start_meas(4'd10, 1'b0);
    n = 0;
    while (!valid && n < 300) begin
      tick();
      n++;
    end
    chk("bp_valid_timeout", int'(valid), 1);
    for (int i = 0; i < 50; i++) begin
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    chk("bp_busy", int'(busy), 1);
    chk("bp_valid_held", int'(valid), 1);
    chk("bp_result_held", int'(result), 10);
    ready = 1'b1;
    tick();
    chk("bp_valid_drop", int'(valid), 0);
    chk("bp_idle", int'(busy), 0);
    repeat (150) tick();
    chk("bp_no_rerun", int'(busy), 0);

    // continuous: period 20 -> 5 edges per window, results every G+2 cycles
    osc_half = 10;
    cont = 1'b1;
    repeat (20) tick();
    c = cyc;
    push(4'd5, 1'b0, c + 2 + G);
    push(4'd5, 1'b0, c + 2 * (2 + G));
    push(4'd5, 1'b0, c + 3 * (2 + G));
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    while (cyc < c + 3 * (2 + G)) begin
      if (!busy) bad++;
      if (cyc == c + 120) cont = 1'b0;
      if (cyc == c + 150) cont = 1'b1;
      if (cyc == c + 210) cont = 1'b0;
      tick();
    end
    chk("cont_busy_gaps", bad, 0);
    repeat (4) tick();
    chk("cont_stop_idle", int'(busy), 0);

    // reset at timer=50, then stuck-low oscillator -> result 0
    osc_half = 5;
    repeat (20) tick();
    c = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < c + 52) tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_overflow", int'(overflow), 0);
    reset = 1'b0;
    osc_half = 0;
    repeat (10) tick();
    start_meas(4'd0, 1'b0);
    wait_idle(300);

    repeat (5) tick();
    chk("sb_empty", sbq.size(), 0);
    chk("pending_valid", rise_cyc, -1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
